test_rand_delay_checking_sink: RTL and testbench



---
 rtl/test_sink_pkg.sv | 24 ++
 rtl/test_lfsr16.sv | 32 +++
 rtl/test_rand_delay_checking_sink.sv | 123 ++++++++++++
 tb/tb_test_rand_delay_checking_sink.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/test_sink_pkg.sv
// Shared definitions for the random-delay test harness (sink, and later the source).
//   state_t            : sink FSM states
//   LFSR_W / LFSR_TAPS : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
//   SINK_DEFAULT_SEED  : seed used when a zero seed is requested
//   NO_ERR_IDX         : first-error index reported when no mismatch occurred
package test_sink_pkg;

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam int unsigned LFSR_W = 16;
  // Feedback taps on bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] SINK_DEFAULT_SEED = 16'hACE1;
  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

  // One left-shift step; the new LSB is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
//   i_clk   : clock
//   i_reset : synchronous active-high reset, loads the seed
//   i_en    : advance one step at the next rising edge
//   o_state : current LFSR state
// A zero seed would lock the register at zero, so it is replaced by the default.
module test_lfsr16
  import test_sink_pkg::*;
#(
  parameter logic [LFSR_W-1:0] p_seed = SINK_DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  localparam logic [LFSR_W-1:0] SEED = (p_seed == '0) ? SINK_DEFAULT_SEED : p_seed;

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/test_rand_delay_checking_sink.sv
// Checking sink for val/rdy test harnesses. Accepts num_msgs messages in order,
// compares each against the expected memory m[], and stalls rdy for a
// pseudo-random number of cycles (0..max_delay) after every accepted message.
//   clk, reset    : clock, synchronous active-high reset
//   max_delay     : upper bound of the stall drawn after each handshake
//   num_msgs      : number of messages expected (<= p_num_msgs)
//   val, rdy, msg : upstream handshake and payload
//   done          : all expected messages accepted
//   err_count     : saturating mismatch count
//   first_err_idx : index of first mismatch, all-ones if none
//   overflow      : sticky, val seen after done
// m[] is loaded hierarchically by the bench before reset deasserts and is not
// cleared by reset.
module test_rand_delay_checking_sink
  import test_sink_pkg::*;
#(
  parameter int unsigned       p_msg_nbits = 1,
  parameter int unsigned       p_num_msgs  = 1024,
  parameter logic [LFSR_W-1:0] p_seed      = SINK_DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic [31:0]            num_msgs,
  input  logic                   val,
  output logic                   rdy,
  input  logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [15:0]            err_count,
  output logic [31:0]            first_err_idx,
  output logic                   overflow
);

  localparam int unsigned AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

  logic [p_msg_nbits-1:0] m [p_num_msgs];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_index;
  logic [15:0]       r_cnt;
  logic [15:0]       r_err_count;
  logic [31:0]       r_first_err_idx;
  logic              r_overflow;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_at_end;
  logic              w_xfer;
  logic              w_mismatch;
  logic [AW-1:0]     w_addr;
  logic [15:0]       w_draw;

  test_lfsr16 #(
    .p_seed (p_seed)
  ) u_lfsr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_xfer),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RECV;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // End-of-run is decoded combinationally from the index so that num_msgs=0
  // reports done (and never raises rdy) in the first cycle after reset.
  always_comb begin
    w_state_nxt = r_state;
    w_at_end    = (r_state == DONE) || (r_index == num_msgs);
    if ((r_state == RECV) && (r_index == num_msgs)) begin
      w_state_nxt = DONE;
    end
    rdy    = !reset && !w_at_end && (r_cnt == '0);
    done   = !reset && w_at_end;
    w_xfer = val && rdy;
  end

  // Modulo in 33 bits so max_delay=all-ones does not wrap to a zero divisor;
  // the remainder is below 2^16 because the dividend is the 16-bit LFSR.
  always_comb begin
    w_addr     = r_index[AW-1:0];
    w_mismatch = (msg != m[w_addr]);
    w_draw     = 16'(({17'd0, w_lfsr} % ({1'b0, max_delay} + 33'd1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index         <= '0;
      r_cnt           <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= NO_ERR_IDX;
      r_overflow      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_index <= r_index + 32'd1;
        r_cnt   <= w_draw;
        if (w_mismatch) begin
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + 16'd1;
          end
          // err_count saturates and never returns to zero, so zero marks "no error yet".
          if (r_err_count == '0) begin
            r_first_err_idx <= r_index;
          end
        end
      end else if ((r_state == RECV) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_at_end && val) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_test_rand_delay_checking_sink.sv
module tb_test_rand_delay_checking_sink;

  localparam int unsigned NB = 8;
  localparam int unsigned NM = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   max_delay = '0;
  logic [31:0]   num_msgs = '0;
  logic          val = 1'b0;
  logic          rdy;
  logic [NB-1:0] msg = '0;
  logic          done;
  logic [15:0]   err_count;
  logic [31:0]   first_err_idx;
  logic          overflow;

  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  logic [15:0]   g_lfsr = 16'hACE1;
  int unsigned   q_gap[$];
  int unsigned   obs_gaps[$];
  logic [NB-1:0] tx [NM];

  always #5 clk = ~clk;

  test_rand_delay_checking_sink #(
    .p_msg_nbits (NB),
    .p_num_msgs  (NM),
    .p_seed      (16'hACE1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .max_delay     (max_delay),
    .num_msgs      (num_msgs),
    .val           (val),
    .rdy           (rdy),
    .msg           (msg),
    .done          (done),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .overflow      (overflow)
  );

  function automatic logic [15:0] g_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_mem(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      dut.m[i] = NB'(i + 1);
      tx[i]    = NB'(i + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    val   = 1'b0;
    #1;
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    g_lfsr = 16'hACE1;
    q_gap.delete();
    #1;
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fei", first_err_idx, 32'hFFFF_FFFF);
    check("rst_ovf", 32'(overflow), 32'd0);
  endtask

  // Drives tx[0..n-1] with val high. Each handshake pushes the golden stall
  // length; it is popped and compared when rdy next rises.
  task automatic stream(input int unsigned n, input int unsigned budget,
                        output int unsigned sent, output int unsigned span);
    int unsigned gap = 0;
    int unsigned cyc = 0;
    int unsigned first_cyc = 0;
    bit          waiting = 1'b0;
    logic [32:0] d;
    sent = 0;
    span = 0;
    obs_gaps.delete();
    while (sent < n && cyc < budget) begin
      @(negedge clk);
      val = 1'b1;
      msg = tx[sent];
      #1;
      if (rdy) begin
        if (waiting) begin
          obs_gaps.push_back(gap);
          check("gap", gap, q_gap.pop_front());
        end else begin
          first_cyc = cyc;
        end
        d = {17'd0, g_lfsr} % ({1'b0, max_delay} + 33'd1);
        q_gap.push_back(d[31:0]);
        g_lfsr  = g_step(g_lfsr);
        waiting = 1'b1;
        gap     = 0;
        sent++;
        span = cyc - first_cyc;
      end else if (waiting) begin
        gap++;
      end
      cyc++;
    end
    @(negedge clk);
    val = 1'b0;
    check("sent", sent, n);
  endtask

  initial begin
    int unsigned sent, span, rdy_seen, first_gap;

    // Full-throughput run, all matching.
    num_msgs  = 4;
    max_delay = 0;
    load_mem(4);
    do_reset();
    check("pre_done", 32'(done), 32'd0);
    stream(4, 50, sent, span);
    #1;
    check("t1_span", span, 32'd3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_fei", first_err_idx, 32'hFFFF_FFFF);
    check("t1_ovf", 32'(overflow), 32'd0);

    // Third message corrupted.
    tx[2] = 8'd7;
    do_reset();
    stream(4, 50, sent, span);
    #1;
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err_count), 32'd1);
    check("t2_fei", first_err_idx, 32'd2);

    // Random stalls, 8 messages.
    num_msgs  = 8;
    max_delay = 3;
    load_mem(8);
    do_reset();
    stream(8, 200, sent, span);
    #1;
    check("t3_done", 32'(done), 32'd1);
    check("t3_err", 32'(err_count), 32'd0);
    check("t3_fei", first_err_idx, 32'hFFFF_FFFF);

    // Extra message after done.
    @(negedge clk);
    val = 1'b1;
    msg = 8'h55;
    @(negedge clk);
    val = 1'b0;
    #1;
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_rdy", 32'(rdy), 32'd0);
    check("t4_err", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    check("t4_done", 32'(done), 32'd1);

    // Zero messages expected.
    num_msgs = 0;
    do_reset();
    check("t5_done", 32'(done), 32'd1);
    rdy_seen = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      val = 1'b1;
      #1;
      if (rdy) rdy_seen++;
    end
    @(negedge clk);
    val = 1'b0;
    check("t5_rdy_never", rdy_seen, 32'd0);
    check("t5_ovf", 32'(overflow), 32'd1);

    // Reset mid-run after two handshakes, then full replay.
    num_msgs  = 4;
    max_delay = 3;
    load_mem(4);
    do_reset();
    stream(2, 50, sent, span);
    check("t6_partial_gaps", obs_gaps.size(), 32'd1);
    first_gap = (obs_gaps.size() > 0) ? obs_gaps[0] : 32'hFFFF_FFFF;
    do_reset();
    check("t6_idx_restart", 32'(done), 32'd0);
    stream(4, 100, sent, span);
    #1;
    check("t6_replay_gap", (obs_gaps.size() > 0) ? obs_gaps[0] : 32'hFFFF_FFFF, first_gap);
    check("t6_done", 32'(done), 32'd1);
    check("t6_err", 32'(err_count), 32'd0);
    check("t6_fei", first_err_idx, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
